// File: rtl/fetch_unit_pkg.sv
// Shared CPU package for the fetch stage.
// Holds the fetch FSM state encoding, the default reset PC and a helper
// that turns the 16-bit branch offset field into a byte offset.
package fetch_unit_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Sign-extend the word offset and scale it to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus between the fetch unit and instruction memory.
// Ports:
//   imem_req   - fetch request (fetch unit -> memory)
//   imem_addr  - fetch byte address (fetch unit -> memory)
//   imem_rdata - returned instruction word (memory -> fetch unit)
//   imem_valid - imem_rdata valid this cycle (memory -> fetch unit)
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_unit_npc.sv
// Next-PC selection for the instruction currently held in issue.
// Ports:
//   pc_plus4           - sequential successor of the current pc
//   branch/jump/jr     - decoded control for the current instruction
//   br_taken           - branch condition result
//   imm16, instr_index - branch / jump target fields
//   rs_val             - register target for jr/jalr
//   next_pc            - selected next fetch address
//   jr_misalign        - jr is selected and its target has nonzero low bits
module npc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        jump,
    input  logic        jr,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    output logic [31:0] next_pc,
    output logic        jr_misalign
);

    // Priority: jr over jump over taken branch over fall-through.
    always_comb begin
        next_pc     = pc_plus4;
        jr_misalign = 1'b0;
        if (jr) begin
            next_pc     = {rs_val[31:2], 2'b00};
            jr_misalign = (rs_val[1:0] != 2'b00);
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr_index, 2'b00};
        end else if (branch && br_taken) begin
            next_pc = pc_plus4 + branch_offset(imm16);
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Two-state instruction fetch unit: FETCH waits for an instruction word,
// ISSUE presents it to decode until it is accepted (stall low), then moves
// pc to the next address chosen by npc.
// Ports:
//   clk, rstn            - clock and asynchronous active-low reset
//   imem                 - instruction memory bus (master side)
//   instr, instr_valid   - registered instruction presented to decode
//   pc, pc_plus4         - address of instr and its link value
//   stall                - downstream holds the current instruction
//   branch, jump, jr, br_taken, imm16, instr_index, rs_val - control for instr
//   misalign             - sticky: a taken jr had a misaligned target
//   retired              - count of issued instructions (wraps)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rstn,
    fetch_unit_if.master       imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               stall,
    input  logic               branch,
    input  logic               jump,
    input  logic               jr,
    input  logic               br_taken,
    input  logic [15:0]        imm16,
    input  logic [25:0]        instr_index,
    input  logic [31:0]        rs_val,
    output logic               misalign,
    output logic [31:0]        retired
);

    fetch_state_e state_r, state_s;
    logic [31:0]  pc_r, pc_s;
    logic [31:0]  instr_r, instr_s;
    logic         instr_valid_r, instr_valid_s;
    logic         misalign_r, misalign_s;
    logic [31:0]  retired_r, retired_s;
    logic [31:0]  pc_plus4_s;
    logic [31:0]  next_pc_s;
    logic         jr_misalign_s;

    assign pc_plus4_s = pc_r + 32'd4;

    npc u_npc (
        .pc_plus4    (pc_plus4_s),
        .branch      (branch),
        .jump        (jump),
        .jr          (jr),
        .br_taken    (br_taken),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .next_pc     (next_pc_s),
        .jr_misalign (jr_misalign_s)
    );

    // Next-state and datapath updates; control inputs only matter when
    // an instruction leaves ISSUE.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        instr_s       = instr_r;
        instr_valid_s = instr_valid_r;
        misalign_s    = misalign_r;
        retired_s     = retired_r;
        case (state_r)
            FETCH: begin
                if (imem.imem_valid) begin
                    instr_s       = imem.imem_rdata;
                    instr_valid_s = 1'b1;
                    state_s       = ISSUE;
                end else begin
                    state_s = FETCH;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    pc_s          = next_pc_s;
                    instr_valid_s = 1'b0;
                    retired_s     = retired_r + 32'd1;
                    misalign_s    = misalign_r | jr_misalign_s;
                    state_s       = FETCH;
                end else begin
                    state_s = ISSUE;
                end
            end
            default: begin
                state_s = FETCH;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            instr_r       <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            misalign_r    <= 1'b0;
            retired_r     <= 32'h0000_0000;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            instr_r       <= instr_s;
            instr_valid_r <= instr_valid_s;
            misalign_r    <= misalign_s;
            retired_r     <= retired_s;
        end
    end

    // Request is gated by reset so memory sees no request while held in reset.
    assign imem.imem_req  = rstn && (state_r == FETCH);
    assign imem.imem_addr = pc_r;
    assign instr          = instr_r;
    assign instr_valid    = instr_valid_r;
    assign pc             = pc_r;
    assign pc_plus4       = pc_plus4_s;
    assign misalign       = misalign_r;
    assign retired        = retired_r;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  fetch byte address; equals pc.
REQ-006 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-007 SHALL have port imem_valid  input  1  imem_rdata valid this cycle.
REQ-008 SHALL have port instr  output  32  registered instruction presented to decode.
REQ-009 SHALL have port instr_valid  output  1  instr is valid.
REQ-010 SHALL have port pc  output  32  address of instr.
REQ-011 SHALL have port pc_plus4  output  32  pc+4, link value for jal/jalr.
REQ-012 SHALL have port stall  input  1  downstream holds current instr.
REQ-013 SHALL have ports branch, jump, jr  input  1 each  decoded control for instr.
REQ-014 SHALL have port br_taken  input  1  branch condition result for instr.
REQ-015 SHALL have port imm16  input  16  branch offset field of instr.
REQ-016 SHALL have port instr_index  input  26  jump target field of instr.
REQ-017 SHALL have port rs_val  input  32  register value for jr/jalr.
REQ-018 SHALL have port misalign  output  1  sticky flag, jr target low bits nonzero.
REQ-019 SHALL have port retired  output  32  count of instructions issued.

Function
REQ-020 SHALL implement a two-state FSM: FETCH, ISSUE.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_valid outside FETCH SHALL be ignored.
REQ-022 FETCH with imem_valid=1 SHALL register imem_rdata into instr, set instr_valid=1 and go to ISSUE next cycle; zero-wait memory gives 2-cycle minimum per instruction.
REQ-023 FETCH with imem_valid=0 SHALL stay in FETCH with pc and imem_req unchanged.
REQ-024 In ISSUE, imem_req SHALL be 0; stall=1 SHALL hold instr, pc, state unchanged.
REQ-025 In ISSUE with stall=0, pc SHALL load next_pc, instr_valid SHALL clear, retired SHALL increment, state SHALL return to FETCH.
REQ-026 next_pc priority SHALL be jr > jump > (branch & br_taken) > pc_plus4.
REQ-027 Branch target SHALL be pc_plus4 + (sign-extended imm16 << 2), modulo 2^32.
REQ-028 Jump target SHALL be {pc_plus4[31:28], instr_index, 2'b00}.
REQ-029 jr target SHALL be {rs_val[31:2], 2'b00}; rs_val[1:0]!=0 on a taken jr SHALL set misalign, held until reset.
REQ-030 branch=1 with br_taken=0 SHALL select pc_plus4.
REQ-031 pc and retired SHALL wrap modulo 2^32 without flag.
REQ-032 Control inputs SHALL be sampled only in ISSUE with stall=0.

Reset
REQ-033 rstn=0 SHALL immediately force pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, misalign=0, retired=0.
REQ-034 imem_req SHALL be 0 while rstn=0 and 1 in the first cycle after release.
REQ-035 Reset asserted mid-FETCH or mid-ISSUE SHALL discard any in-flight word; a imem_valid in the release cycle's edge SHALL not be captured.

Structure
REQ-036 State encoding and default RESET_PC SHALL live in the shared CPU package.
REQ-037 next_pc logic SHALL be a combinational sub-module named npc; fetch_unit holds FSM, pc, instr, counters.

Verification
REQ-038 Reset release, imem_valid tied 1, no control -> imem_addr 3000, 3004, 3008 on alternate cycles; retired=3 after 6 cycles.
REQ-039 pc=3000, branch=1, br_taken=1, imm16=16'hFFFF -> next imem_addr 3000; with br_taken=0 -> 3004.
REQ-040 pc=3000_0010, jump=1, instr_index=26'h0000040 -> next imem_addr 3000_0100.
REQ-041 jr=1, jump=1, rs_val=32'h0000_4006 -> next imem_addr 4004, misalign=1 and stays 1.
REQ-042 imem_valid low 3 cycles in FETCH, then stall=1 for 2 cycles in ISSUE -> pc, instr stable throughout, retired increments once.
REQ-043 rstn pulsed low in ISSUE with pc=3010 -> pc=3000, instr_valid=0 immediately, refetch from 3000.
